// File: rtl/tracker_scan_if.sv
// tracker_scan_if: bundle between the raster scan generator and its two peers.
//   PIX_CE          pixel clock enable into the scanner
//   on              tracker pixel state returned for the current scan address
//   hcnt, vcnt      scan address (active column, linear active address)
//   o_hsync/o_vsync active-low syncs toward the frame sink
//   o_de, o_rgb     data enable and pixel colour
//   o_valid, o_sof  new-pixel strobe and start-of-frame pulse
// master: the scanner.  slave: the tracker/sink side (or a testbench).
interface tracker_scan_if;
  logic        PIX_CE;
  logic        on;
  logic [13:0] hcnt;
  logic [23:0] vcnt;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_de;
  logic [23:0] o_rgb;
  logic        o_valid;
  logic        o_sof;

  modport master (
    input  PIX_CE, on,
    output hcnt, vcnt, o_hsync, o_vsync, o_de, o_rgb, o_valid, o_sof
  );

  modport slave (
    output PIX_CE, on,
    input  hcnt, vcnt, o_hsync, o_vsync, o_de, o_rgb, o_valid, o_sof
  );
endinterface

// File: rtl/tracker_scan.sv
// tracker_scan: raster scan generator. Issues active-area scan addresses to the
// tracker, takes back its registered `on` bit and emits a timed RGB stream with
// syncs, aligned 2 CLK behind the address.
//   CLK    system clock
//   RESET  asynchronous active-high reset
//   bus    tracker_scan_if.master (PIX_CE/on in; hcnt, vcnt and video outputs out)
module tracker_scan #(
  parameter int unsigned HACT   = 480,
  parameter int unsigned HFP    = 8,
  parameter int unsigned HSW    = 32,
  parameter int unsigned HBP    = 40,
  parameter int unsigned VACT   = 270,
  parameter int unsigned VFP    = 3,
  parameter int unsigned VSW    = 5,
  parameter int unsigned VBP    = 6,
  parameter logic [23:0] FG_RGB = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB = 24'h000000
) (
  input logic            CLK,
  input logic            RESET,
  tracker_scan_if.master bus
);
  // Last position of each phase; a phase ends on the PIX_CE cycle at that position.
  localparam logic [13:0] H_ACT_END  = 14'(HACT - 1);
  localparam logic [13:0] H_FP_END   = 14'(HACT + HFP - 1);
  localparam logic [13:0] H_SYNC_END = 14'(HACT + HFP + HSW - 1);
  localparam logic [13:0] H_TOT_END  = 14'(HACT + HFP + HSW + HBP - 1);
  localparam logic [13:0] V_ACT_END  = 14'(VACT - 1);
  localparam logic [13:0] V_FP_END   = 14'(VACT + VFP - 1);
  localparam logic [13:0] V_SYNC_END = 14'(VACT + VFP + VSW - 1);
  localparam logic [13:0] V_TOT_END  = 14'(VACT + VFP + VSW + VBP - 1);
  localparam logic [23:0] LINE_STEP  = 24'(HACT);

  typedef enum logic [1:0] {StAct, StFp, StSync, StBp} phase_e;

  phase_e      h_state, v_state;
  logic [13:0] hpos, vpos;
  logic [23:0] addr;   // linear address of the current active pixel
  logic [23:0] vbase;  // vpos*HACT for the current active line
  logic        active, line_end, frame_end;

  logic de1, hs1, vs1, ce1, org1;

  assign active    = (h_state == StAct) && (v_state == StAct);
  assign line_end  = (hpos == H_TOT_END);
  assign frame_end = line_end && (vpos == V_TOT_END);

  assign bus.hcnt = active ? hpos : '0;
  assign bus.vcnt = active ? addr : '0;

  // Stage 0: position counters, phase FSMs and linear address.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hpos    <= '0;
      vpos    <= '0;
      h_state <= StAct;
      v_state <= StAct;
      addr    <= '0;
      vbase   <= '0;
    end else if (bus.PIX_CE) begin
      hpos <= line_end ? '0 : hpos + 14'd1;

      case (h_state)
        StAct:   if (hpos == H_ACT_END)  h_state <= StFp;
        StFp:    if (hpos == H_FP_END)   h_state <= StSync;
        StSync:  if (hpos == H_SYNC_END) h_state <= StBp;
        StBp:    if (line_end)           h_state <= StAct;
        default: h_state <= StAct;
      endcase

      if (line_end) begin
        vpos <= frame_end ? '0 : vpos + 14'd1;
        case (v_state)
          StAct:   if (vpos == V_ACT_END)  v_state <= StFp;
          StFp:    if (vpos == V_FP_END)   v_state <= StSync;
          StSync:  if (vpos == V_SYNC_END) v_state <= StBp;
          StBp:    if (vpos == V_TOT_END)  v_state <= StAct;
          default: v_state <= StAct;
        endcase
      end

      // Line starts reload from the shadow base so addr never depends on a multiply.
      if (frame_end) begin
        vbase <= '0;
        addr  <= '0;
      end else if (line_end) begin
        if (v_state == StAct) begin
          vbase <= vbase + LINE_STEP;
          addr  <= vbase + LINE_STEP;
        end
      end else if (active) begin
        addr <= addr + 24'd1;
      end
    end
  end

  // Stages 1 and 2 clock every CLK; `on` arrives aligned with stage 1.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      de1         <= 1'b0;
      hs1         <= 1'b1;
      vs1         <= 1'b1;
      ce1         <= 1'b0;
      org1        <= 1'b0;
      bus.o_de    <= 1'b0;
      bus.o_hsync <= 1'b1;
      bus.o_vsync <= 1'b1;
      bus.o_rgb   <= '0;
      bus.o_valid <= 1'b0;
      bus.o_sof   <= 1'b0;
    end else begin
      de1         <= active;
      hs1         <= (h_state != StSync);
      vs1         <= (v_state != StSync);
      ce1         <= bus.PIX_CE;
      org1        <= active && (hpos == '0) && (vpos == '0);
      bus.o_de    <= de1;
      bus.o_hsync <= hs1;
      bus.o_vsync <= vs1;
      bus.o_rgb   <= de1 ? (bus.on ? FG_RGB : BG_RGB) : '0;
      bus.o_valid <= ce1;
      bus.o_sof   <= ce1 & de1 & org1;
    end
  end
endmodule

// File: tb/tb_tracker_scan.sv
// Testbench for tracker_scan: default-timing instance with a scoreboard monitor
// and a 1-CLK tracker model, plus a minimal-porch instance for whole-frame checks.
`timescale 1ns/1ps
module tb_tracker_scan;
  localparam int HACT = 480, HFP = 8, HSW = 32, HBP = 40;
  localparam int VACT = 270, VFP = 3, VSW = 5, VBP = 6;
  localparam int HTOT = HACT + HFP + HSW + HBP;
  localparam int VTOT = VACT + VFP + VSW + VBP;
  localparam int SH = 8, SV = 4, SHT = SH + 3, SVT = SV + 3;
  localparam int NREC = 5 * HTOT;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
    logic        valid;
    logic        sof;
  } exp_t;

  localparam exp_t RST_E = {1'b0, 1'b1, 1'b1, 24'h0, 1'b0, 1'b0};

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  tracker_scan_if bus ();
  tracker_scan_if bus_s ();

  tracker_scan u_dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  tracker_scan #(
    .HACT (SH), .HFP (1), .HSW (1), .HBP (1),
    .VACT (SV), .VFP (1), .VSW (1), .VBP (1)
  ) u_small (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus_s)
  );

  int   total = 0;
  int   bad = 0;
  int   rh = 0, rv = 0;
  exp_t sbq[$];
  logic [23:0] rec_rgb [NREC];

  // Tracker model: lit for x<5, y<5, registered one CLK behind the address.
  always @(posedge CLK) bus.on <= (bus.hcnt < 14'd5) && (bus.vcnt < 24'(5 * HACT));
  initial bus_s.on = 1'b0;

  exp_t m_e, m_got;
  logic m_act;
  int   m_eh, m_ev;

  // Scoreboard: expected outputs are pushed for each addressed cycle and
  // compared two cycles later.
  always @(negedge CLK) begin
    if (!RESET) begin
      m_act = (rh < HACT) && (rv < VACT);
      m_eh  = m_act ? rh : 0;
      m_ev  = m_act ? rv * HACT + rh : 0;
      total++;
      if (bus.hcnt !== 14'(m_eh)) begin
        bad++;
        $display("FAIL sb_hcnt t=%0t got=%0d want=%0d", $time, bus.hcnt, m_eh);
      end
      total++;
      if (bus.vcnt !== 24'(m_ev)) begin
        bad++;
        $display("FAIL sb_vcnt t=%0t got=%0d want=%0d", $time, bus.vcnt, m_ev);
      end
      m_e.de    = m_act;
      m_e.hs    = !(rh >= HACT + HFP && rh < HACT + HFP + HSW);
      m_e.vs    = !(rv >= VACT + VFP && rv < VACT + VFP + VSW);
      m_e.rgb   = (m_act && rh < 5 && rv < 5) ? 24'hFFFFFF : 24'h000000;
      m_e.valid = bus.PIX_CE;
      m_e.sof   = bus.PIX_CE && m_act && rh == 0 && rv == 0;
      sbq.push_back(m_e);
      if (sbq.size() > 2) begin
        m_e   = sbq.pop_front();
        m_got = {bus.o_de, bus.o_hsync, bus.o_vsync, bus.o_rgb, bus.o_valid, bus.o_sof};
        total++;
        if (m_got !== m_e) begin
          bad++;
          $display("FAIL sb_out t=%0t got{de,hs,vs,rgb,valid,sof}=%h want=%h",
                   $time, m_got, m_e);
        end
      end
      if (bus.PIX_CE) begin
        if (rh == HTOT - 1) begin
          rh = 0;
          rv = (rv == VTOT - 1) ? 0 : rv + 1;
        end else begin
          rh++;
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the first edge out of reset.
  task automatic do_reset(input logic ce);
    RESET = 1'b1;
    rh = 0;
    rv = 0;
    sbq.delete();
    sbq.push_back(RST_E);
    sbq.push_back(RST_E);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    bus.PIX_CE = ce;
    bus_s.PIX_CE = ce;
  endtask

  task automatic test_reset();
    bus.PIX_CE = 1'b0;
    bus_s.PIX_CE = 1'b0;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if ({bus.hcnt, bus.vcnt} !== 38'd0) begin
      bad++;
      $display("FAIL reset_addr got hcnt=%0d vcnt=%0d want 0 0", bus.hcnt, bus.vcnt);
    end
    total++;
    if ({bus.o_de, bus.o_hsync, bus.o_vsync, bus.o_rgb, bus.o_valid, bus.o_sof} !== RST_E) begin
      bad++;
      $display("FAIL reset_out got de=%b hs=%b vs=%b rgb=%h valid=%b sof=%b want 0 1 1 0 0 0",
               bus.o_de, bus.o_hsync, bus.o_vsync, bus.o_rgb, bus.o_valid, bus.o_sof);
    end
    // Out of reset with PIX_CE low: address must hold at (0,0), o_valid stays 0.
    do_reset(1'b0);
    repeat (6) @(posedge CLK);
    #1;
    bus.PIX_CE = 1'b1;
  endtask

  task automatic test_line();
    int first_low, nlow, nwhite, nrec;
    first_low = -1;
    nlow = 0;
    nwhite = 0;
    nrec = 0;
    do_reset(1'b1);
    for (int k = 0; k < 6 * HTOT + 2; k++) begin
      @(negedge CLK);
      if (k == HACT - 1 || k == HACT || k == HTOT) begin
        total++;
        if (bus.hcnt !== ((k == HACT - 1) ? 14'(HACT - 1) : 14'd0)) begin
          bad++;
          $display("FAIL line_hcnt k=%0d got=%0d", k, bus.hcnt);
        end
      end
      if (k == HTOT) begin
        total++;
        if (bus.vcnt !== 24'd480) begin
          bad++;
          $display("FAIL line1_vcnt got=%0d want=480", bus.vcnt);
        end
      end
      if (k < HTOT + 2 && bus.o_hsync === 1'b0) begin
        if (first_low < 0) first_low = k;
        nlow++;
      end
      if (bus.o_rgb === 24'hFFFFFF) nwhite++;
      if (bus.o_valid === 1'b1 && nrec < NREC) begin
        rec_rgb[nrec] = bus.o_rgb;
        nrec++;
      end
    end
    total++;
    if (first_low != 488 + 2 || nlow != HSW) begin
      bad++;
      $display("FAIL hsync_pulse got start=%0d len=%0d want start=490 len=32", first_low, nlow);
    end
    total++;
    if (nwhite != 25) begin
      bad++;
      $display("FAIL white_pixels got=%0d want=25", nwhite);
    end
  endtask

  task automatic test_ce_third();
    int nrec, ndiff, first_diff, nhold_bad;
    logic [23:0] prev_rgb;
    logic prev_valid, prev_de;
    nrec = 0;
    ndiff = 0;
    first_diff = -1;
    nhold_bad = 0;
    prev_rgb = '0;
    prev_valid = 1'b0;
    prev_de = 1'b0;
    do_reset(1'b1);
    for (int k = 0; k < 3 * NREC + 12 && nrec < NREC; k++) begin
      @(negedge CLK);
      if (k >= 3 && prev_valid === 1'b0 && (bus.o_rgb !== prev_rgb || bus.o_de !== prev_de))
        nhold_bad++;
      if (bus.o_valid === 1'b1) begin
        if (bus.o_rgb !== rec_rgb[nrec]) begin
          ndiff++;
          if (first_diff < 0) first_diff = nrec;
        end
        nrec++;
      end
      prev_rgb = bus.o_rgb;
      prev_valid = bus.o_valid;
      prev_de = bus.o_de;
      @(posedge CLK);
      #1;
      bus.PIX_CE = ((k + 1) % 3 == 0);
    end
    bus.PIX_CE = 1'b1;
    total++;
    if (nrec != NREC) begin
      bad++;
      $display("FAIL ce_pixel_count got=%0d want=%0d", nrec, NREC);
    end
    total++;
    if (ndiff != 0) begin
      bad++;
      $display("FAIL ce_rgb_seq got diffs=%0d first=%0d want 0", ndiff, first_diff);
    end
    total++;
    if (nhold_bad != 0) begin
      bad++;
      $display("FAIL ce_hold got unstable=%0d want 0", nhold_bad);
    end
  endtask

  task automatic test_mid_reset();
    do_reset(1'b1);
    repeat (2 * HTOT + 200) @(posedge CLK);
    #1;
    total++;
    if (bus.hcnt !== 14'd200 || bus.vcnt !== 24'(2 * HACT + 200) || bus.o_de !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset got hcnt=%0d vcnt=%0d de=%b want 200 1160 1",
               bus.hcnt, bus.vcnt, bus.o_de);
    end
    RESET = 1'b1;
    #1;
    total++;
    if ({bus.o_de, bus.o_hsync, bus.o_vsync, bus.o_rgb, bus.o_valid, bus.o_sof} !== RST_E ||
        bus.hcnt !== 14'd0 || bus.vcnt !== 24'd0) begin
      bad++;
      $display("FAIL mid_reset got hcnt=%0d vcnt=%0d de=%b hs=%b vs=%b rgb=%h valid=%b sof=%b",
               bus.hcnt, bus.vcnt, bus.o_de, bus.o_hsync, bus.o_vsync, bus.o_rgb,
               bus.o_valid, bus.o_sof);
    end
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        total++;
        if (bus.hcnt !== 14'd0 || bus.vcnt !== 24'd0) begin
          bad++;
          $display("FAIL post_reset_addr got hcnt=%0d vcnt=%0d want 0 0", bus.hcnt, bus.vcnt);
        end
      end
      total++;
      if (bus.o_sof !== (k == 2)) begin
        bad++;
        $display("FAIL post_reset_sof k=%0d got=%b want=%b", k, bus.o_sof, (k == 2));
      end
    end
  endtask

  task automatic test_small_frames();
    int p, h, v, vmax, nvs, nhs, nde, nsof;
    logic act;
    logic [3:0] got4, want4;
    vmax = 0;
    nvs = 0;
    nhs = 0;
    nde = 0;
    nsof = 0;
    do_reset(1'b1);
    for (int k = 0; k < 2 * SHT * SVT + 2; k++) begin
      @(negedge CLK);
      h = k % SHT;
      v = (k / SHT) % SVT;
      act = (h < SH) && (v < SV);
      total++;
      if (bus_s.hcnt !== (act ? 14'(h) : 14'd0) ||
          bus_s.vcnt !== (act ? 24'(v * SH + h) : 24'd0)) begin
        bad++;
        $display("FAIL small_addr k=%0d got hcnt=%0d vcnt=%0d want %0d %0d", k, bus_s.hcnt,
                 bus_s.vcnt, act ? h : 0, act ? v * SH + h : 0);
      end
      if (int'(bus_s.vcnt) > vmax) vmax = int'(bus_s.vcnt);
      if (k >= 2) begin
        p = k - 2;
        h = p % SHT;
        v = (p / SHT) % SVT;
        want4 = {(h < SH) && (v < SV), h != SH + 1, v != SV + 1, h == 0 && v == 0};
        got4 = {bus_s.o_de, bus_s.o_hsync, bus_s.o_vsync, bus_s.o_sof};
        total++;
        if (got4 !== want4) begin
          bad++;
          $display("FAIL small_out k=%0d got{de,hs,vs,sof}=%b want=%b", k, got4, want4);
        end
        if (bus_s.o_vsync === 1'b0) nvs++;
        if (bus_s.o_hsync === 1'b0) nhs++;
        if (bus_s.o_de === 1'b1) nde++;
        if (bus_s.o_sof === 1'b1) nsof++;
      end
    end
    total++;
    if (vmax != SH * SV - 1) begin
      bad++;
      $display("FAIL small_vcnt_peak got=%0d want=%0d", vmax, SH * SV - 1);
    end
    total++;
    if (nvs != 2 * SHT || nhs != 2 * SVT || nde != 2 * SH * SV || nsof != 2) begin
      bad++;
      $display("FAIL small_counts got vs=%0d hs=%0d de=%0d sof=%0d want %0d %0d %0d 2",
               nvs, nhs, nde, nsof, 2 * SHT, 2 * SVT, 2 * SH * SV);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_ce_third();
    test_mid_reset();
    test_small_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/tracker_scan.md
# tracker_scan

Raster scan generator that drives the tracker's scan-address inputs and turns its returned `on` bit into a timed video stream for the vgasim frame sink. Produces the active-area pixel coordinates (`hcnt`, linear `vcnt`) consumed by the tracker, horizontal/vertical sync and blanking, and a 2-cycle aligned RGB output. It is the counterpart of the tracker: the tracker reads scan addresses and answers with pixel state, and this block issues the addresses and consumes the state.

## Interface
- HACT, 480: active pixels per line (96 cells × 5)
- HFP, 8: horizontal front porch, pixels
- HSW, 32: hsync width, pixels
- HBP, 40: horizontal back porch, pixels
- VACT, 270: active lines (54 cells × 5)
- VFP, 3: vertical front porch, lines
- VSW, 5: vsync width, lines
- VBP, 6: vertical back porch, lines
- FG_RGB, 24'hFFFFFF: colour when `on`=1
- BG_RGB, 24'h000000: colour when `on`=0 in active area
- CLK  in  1  system clock; one clock for the whole block
- RESET  in  1  asynchronous, active-high reset
- PIX_CE  in  1  pixel clock enable; counters advance only on cycles with PIX_CE=1
- on  in  1  tracker pixel state; registered in the tracker, valid 1 CLK after `hcnt`/`vcnt` change
- hcnt  out  14  active column x, 0..HACT-1; 0 during blanking
- vcnt  out  24  linear active address y*HACT + x; 0 during blanking
- o_hsync  out  1  active-low hsync
- o_vsync  out  1  active-low vsync
- o_de  out  1  data enable, high for active pixels
- o_rgb  out  24  pixel colour {R,G,B}, 0 when `o_de`=0
- o_valid  out  1  PIX_CE delayed 2 CLK; marks a new output pixel
- o_sof  out  1  one-CLK pulse with the first active pixel of a frame on the outputs

## Operation
- Horizontal counter `hpos` 0..HTOT-1, where HTOT = HACT+HFP+HSW+HBP (560). It increments on PIX_CE and wraps to 0.
- Vertical counter `vpos` 0..VTOT-1, where VTOT = VACT+VFP+VSW+VBP (284). It increments on PIX_CE when `hpos`=HTOT-1 and wraps to 0.
- Horizontal phase FSM, derived from `hpos` boundaries: H_ACT → H_FP → H_SYNC → H_BP → H_ACT. It changes state on the PIX_CE cycle that reaches each boundary.
- Vertical phase FSM: V_ACT → V_FP → V_SYNC → V_BP → V_ACT. It changes state only at end of line.
- Active = H_ACT and V_ACT.
- `hcnt` = `hpos` while active, else 0.
- `vcnt` is a running linear address:
  - incremented by 1 for each active pixel;
  - reset to 0 at the start of V_ACT line 0;
  - forced to 0 whenever not active;
  - at the start of each active line it equals `vpos`*HACT. It is kept as a shadow base register, not built with a multiplier.
- The maximum `vcnt` value is HACT*VACT-1 = 129599. All arithmetic is unsigned, and `vcnt` never exceeds 24 bits.
- Stage 1 (every CLK): register de, hsync and vsync from the stage-0 counters, plus PIX_CE.
- Stage 2 (every CLK):
  - `o_rgb` = de1 ? (on ? FG_RGB : BG_RGB) : 0;
  - `o_de`, `o_hsync` and `o_vsync` come from stage 1;
  - `o_valid` = ce1;
  - `o_sof` = ce1 & de1 & (stage-1 position was x=0, y=0).
- hsync is asserted (low) throughout H_SYNC on every line. vsync is asserted (low) for the whole of V_SYNC lines.

## Timing
- Reset values:
  - `hpos`, `vpos`, `hcnt`, `vcnt` = 0, and both FSMs in ACT;
  - `o_hsync` = `o_vsync` = 1;
  - `o_de` = `o_valid` = `o_sof` = 0, `o_rgb` = 0.
- Latency: the output pixel corresponding to an `hcnt`/`vcnt` value appears exactly 2 CLK after that value is driven, independent of the PIX_CE pattern.
- PIX_CE=0: counters and `hcnt`/`vcnt` hold, and the pipeline keeps clocking.
  - Outputs for a held address stay stable.
  - `o_valid` is 0 on the corresponding output cycles.
- Simultaneous line and frame wrap on one PIX_CE cycle: `hpos`→0, `vpos`→0 and `vcnt`→0 in the same cycle.
- RESET mid-frame returns everything to the reset values immediately. The first PIX_CE after release addresses pixel (0,0).
- After reset, `o_sof` first fires 2 CLK after the first PIX_CE cycle that presents (0,0).

## Test plan
- Reset then PIX_CE=1 continuously:
  - `hcnt` steps 0..479, then holds 0 for 80 cycles;
  - `vcnt` at line 1 start = 480;
  - `o_hsync` low for exactly 32 cycles starting at `hpos` 488.
- Full frame: `vcnt` peaks at 129599, and `vcnt`=0 on the first active pixel of the next frame; `o_vsync` is low for exactly 5×560 pixels; `o_sof` pulses once per 284×560 cycles.
- Tie `on`=1 for x<5, y<5 (a tracker model with a 1-CLK register): `o_rgb` = FFFFFF on those 25 pixels per frame, 000000 on the other active pixels, and 0 in blanking.
- PIX_CE = 1-in-3 pattern: each output pixel holds for 3 CLK with `o_valid` high only on the first; the RGB sequence is identical to the continuous run.
- Assert RESET at `hpos`=200, `vpos`=100 for 1 cycle: outputs go to reset values the same cycle, and the next pixel addressed is `hcnt`=0, `vcnt`=0.
- Reduce porch parameters to HFP=1, HSW=1, HBP=1, VFP=1, VSW=1, VBP=1: phase sequencing still holds and there are no zero-width or missing phases.
